// File: rtl/anf_fl_tex_etc_stream_decoder.sv
// Streaming ETC1 4x4 block decoder: one block in, 16 RGBA8 texels out over 16/LANES beats.
// Optional EAC alpha decode is enabled by defining ANF_FL_TEX_EAC_ALPHA_EN (s_data becomes 128 bits).
module anf_fl_tex_etc_stream_decoder #(
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
    input  logic [127:0]          s_data,
`else
    input  logic [63:0]           s_data,
`endif
    input  logic [TAG_W-1:0]      s_tag,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LANES*32-1:0]   m_rgba,
    output logic [3:0]            m_beat,
    output logic                  m_last,
    output logic                  m_etc2,
    output logic [TAG_W-1:0]      m_tag
);

    localparam int unsigned BEATS = 16 / LANES;
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
    localparam int unsigned DATA_W = 128;
`else
    localparam int unsigned DATA_W = 64;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BASE,
        ST_EMIT
    } state_e;

    localparam logic [7:0] ETC_A [8] = '{8'd2, 8'd5, 8'd9, 8'd13, 8'd18, 8'd24, 8'd33, 8'd47};
    localparam logic [7:0] ETC_B [8] = '{8'd8, 8'd17, 8'd29, 8'd42, 8'd60, 8'd80, 8'd106, 8'd183};

`ifdef ANF_FL_TEX_EAC_ALPHA_EN
    localparam logic signed [4:0] EAC_TBL [16][8] = '{
        '{-5'sd3, -5'sd6, -5'sd9, -5'sd15, 5'sd2, 5'sd5, 5'sd8, 5'sd14},
        '{-5'sd3, -5'sd7, -5'sd10, -5'sd13, 5'sd2, 5'sd6, 5'sd9, 5'sd12},
        '{-5'sd2, -5'sd5, -5'sd8, -5'sd13, 5'sd1, 5'sd4, 5'sd7, 5'sd12},
        '{-5'sd2, -5'sd4, -5'sd6, -5'sd13, 5'sd1, 5'sd3, 5'sd5, 5'sd12},
        '{-5'sd3, -5'sd6, -5'sd8, -5'sd12, 5'sd2, 5'sd5, 5'sd7, 5'sd11},
        '{-5'sd3, -5'sd7, -5'sd9, -5'sd11, 5'sd2, 5'sd6, 5'sd8, 5'sd10},
        '{-5'sd4, -5'sd7, -5'sd8, -5'sd11, 5'sd3, 5'sd6, 5'sd7, 5'sd10},
        '{-5'sd3, -5'sd5, -5'sd8, -5'sd11, 5'sd2, 5'sd4, 5'sd7, 5'sd10},
        '{-5'sd2, -5'sd6, -5'sd8, -5'sd10, 5'sd1, 5'sd5, 5'sd7, 5'sd9},
        '{-5'sd2, -5'sd5, -5'sd8, -5'sd10, 5'sd1, 5'sd4, 5'sd7, 5'sd9},
        '{-5'sd2, -5'sd4, -5'sd8, -5'sd10, 5'sd1, 5'sd3, 5'sd7, 5'sd9},
        '{-5'sd2, -5'sd5, -5'sd7, -5'sd10, 5'sd1, 5'sd4, 5'sd6, 5'sd9},
        '{-5'sd3, -5'sd4, -5'sd7, -5'sd10, 5'sd2, 5'sd3, 5'sd6, 5'sd9},
        '{-5'sd1, -5'sd2, -5'sd3, -5'sd10, 5'sd0, 5'sd1, 5'sd2, 5'sd9},
        '{-5'sd4, -5'sd6, -5'sd8, -5'sd9, 5'sd3, 5'sd5, 5'sd7, 5'sd8},
        '{-5'sd3, -5'sd5, -5'sd7, -5'sd9, 5'sd2, 5'sd4, 5'sd6, 5'sd8}
    };
`endif

    state_e              state_q, state_d;
    logic [3:0]          beat_q, beat_d;
    logic [DATA_W-1:0]   blk_q, blk_d;
    logic [TAG_W-1:0]    tag_in_q, tag_in_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [2:0][7:0]     base1_q, base1_d;
    logic [2:0][7:0]     base2_q, base2_d;
    logic [2:0]          cw1_q, cw1_d;
    logic [2:0]          cw2_q, cw2_d;
    logic                flip_q, flip_d;
    logic [31:0]         idx_q, idx_d;
    logic                etc2_q, etc2_d;
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
    logic [7:0]          a_base_q, a_base_d;
    logic [3:0]          a_mult_q, a_mult_d;
    logic [3:0]          a_tbl_q, a_tbl_d;
    logic [47:0]         a_idx_q, a_idx_d;
`endif

    logic                beat_last;
    logic                accept;
    logic [2:0][7:0]     calc_base1;
    logic [2:0][7:0]     calc_base2;
    logic                calc_esc;

    assign beat_last = (beat_q == 4'(BEATS - 1));
    assign s_ready   = (state_q == ST_IDLE) || ((state_q == ST_EMIT) && m_ready && beat_last);
    assign accept    = s_valid && s_ready;

    // Base colours of both subblocks; index 2 is R, 1 is G, 0 is B.
    always_comb begin
        logic [4:0] c1;
        logic [2:0] d3;
        logic [6:0] sum;
        logic [3:0] i1;
        logic [3:0] i2;
        calc_base1 = '0;
        calc_base2 = '0;
        calc_esc   = 1'b0;
        c1  = '0;
        d3  = '0;
        sum = '0;
        i1  = '0;
        i2  = '0;
        for (int ch = 0; ch < 3; ch++) begin
            c1  = blk_q[47 + 8*ch -: 5];
            d3  = blk_q[42 + 8*ch -: 3];
            i1  = blk_q[47 + 8*ch -: 4];
            i2  = blk_q[43 + 8*ch -: 4];
            // Out-of-range 5-bit sums show up as bit 6 (negative) or bit 5 (>31).
            sum = {2'b00, c1} + {{4{d3[2]}}, d3};
            if (blk_q[33]) begin
                calc_base1[ch] = {c1, c1[4:2]};
                calc_base2[ch] = {sum[4:0], sum[4:2]};
                calc_esc       = calc_esc | sum[6] | sum[5];
            end else begin
                calc_base1[ch] = {i1, i1};
                calc_base2[ch] = {i2, i2};
            end
        end
    end

    function automatic logic [7:0] clamp8(input logic signed [9:0] v);
        if (v < 10'sd0) begin
            return 8'd0;
        end
        if (v > 10'sd255) begin
            return 8'hFF;
        end
        return v[7:0];
    endfunction

    // Decode raster texel t from the registered block state.
    function automatic logic [31:0] texel(input logic [3:0] t);
        logic [3:0]        p;
        logic              sub2;
        logic [2:0]        cw;
        logic [2:0][7:0]   base;
        logic [7:0]        mag;
        logic signed [9:0] mod;
        logic [7:0]        r;
        logic [7:0]        g;
        logic [7:0]        b;
        logic [7:0]        a;
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
        logic [2:0]        ai;
        logic signed [9:0] am;
`endif
        p    = {t[1:0], t[3:2]};
        sub2 = flip_q ? t[3] : t[1];
        cw   = sub2 ? cw2_q : cw1_q;
        base = sub2 ? base2_q : base1_q;
        mag  = idx_q[{1'b0, p}] ? ETC_B[cw] : ETC_A[cw];
        mod  = idx_q[{1'b1, p}] ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
        r    = clamp8($signed({2'b00, base[2]}) + mod);
        g    = clamp8($signed({2'b00, base[1]}) + mod);
        b    = clamp8($signed({2'b00, base[0]}) + mod);
        if (etc2_q) begin
            r = 8'd0;
            g = 8'd0;
            b = 8'd0;
        end
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
        ai = a_idx_q[47 - 3*int'(p) -: 3];
        am = 10'(EAC_TBL[a_tbl_q][ai]) * $signed({6'b000000, a_mult_q});
        a  = clamp8($signed({2'b00, a_base_q}) + am);
`else
        a  = 8'hFF;
`endif
        return {r, g, b, a};
    endfunction

    // Lane L of beat k carries raster texel k*LANES+L.
    always_comb begin
        m_rgba = '0;
        if (state_q == ST_EMIT) begin
            for (int l = 0; l < int'(LANES); l++) begin
                m_rgba[32*l +: 32] = texel(4'(int'(beat_q) * int'(LANES) + l));
            end
        end
    end

    assign m_valid = (state_q == ST_EMIT);
    assign m_last  = (state_q == ST_EMIT) && beat_last;
    assign m_etc2  = (state_q == ST_EMIT) && etc2_q;
    assign m_beat  = 4'(int'(beat_q) * int'(LANES));
    assign m_tag   = tag_q;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        blk_d    = blk_q;
        tag_in_d = tag_in_q;
        tag_d    = tag_q;
        base1_d  = base1_q;
        base2_d  = base2_q;
        cw1_d    = cw1_q;
        cw2_d    = cw2_q;
        flip_d   = flip_q;
        idx_d    = idx_q;
        etc2_d   = etc2_q;
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
        a_base_d = a_base_q;
        a_mult_d = a_mult_q;
        a_tbl_d  = a_tbl_q;
        a_idx_d  = a_idx_q;
`endif
        if (accept) begin
            blk_d    = s_data;
            tag_in_d = s_tag;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BASE;
                end
            end
            ST_BASE: begin
                base1_d = calc_base1;
                base2_d = calc_base2;
                cw1_d   = blk_q[39:37];
                cw2_d   = blk_q[36:34];
                flip_d  = blk_q[32];
                idx_d   = blk_q[31:0];
                etc2_d  = calc_esc;
                tag_d   = tag_in_q;
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
                a_base_d = blk_q[127:120];
                a_mult_d = blk_q[119:116];
                a_tbl_d  = blk_q[115:112];
                a_idx_d  = blk_q[111:64];
`endif
                beat_d  = 4'd0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (m_ready) begin
                    if (beat_last) begin
                        beat_d  = 4'd0;
                        state_d = accept ? ST_BASE : ST_IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            blk_q    <= '0;
            tag_in_q <= '0;
            tag_q    <= '0;
            base1_q  <= '0;
            base2_q  <= '0;
            cw1_q    <= '0;
            cw2_q    <= '0;
            flip_q   <= 1'b0;
            idx_q    <= '0;
            etc2_q   <= 1'b0;
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
            a_base_q <= '0;
            a_mult_q <= '0;
            a_tbl_q  <= '0;
            a_idx_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            blk_q    <= blk_d;
            tag_in_q <= tag_in_d;
            tag_q    <= tag_d;
            base1_q  <= base1_d;
            base2_q  <= base2_d;
            cw1_q    <= cw1_d;
            cw2_q    <= cw2_d;
            flip_q   <= flip_d;
            idx_q    <= idx_d;
            etc2_q   <= etc2_d;
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
            a_base_q <= a_base_d;
            a_mult_q <= a_mult_d;
            a_tbl_q  <= a_tbl_d;
            a_idx_q  <= a_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_anf_fl_tex_etc_stream_decoder.sv
// Randomized bench for anf_fl_tex_etc_stream_decoder against a per-texel reference model.
module tb_anf_fl_tex_etc_stream_decoder;

    localparam int unsigned LANES = 4;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned BEATS = 16 / LANES;
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
    localparam int unsigned DW = 128;
`else
    localparam int unsigned DW = 64;
`endif

    typedef logic [DW-1:0] blk_t;
    typedef struct packed {
        logic [511:0]     tx;
        logic [TAG_W-1:0] tag;
        logic             esc;
    } exp_t;

    localparam int ETC_A [8] = '{2, 5, 9, 13, 18, 24, 33, 47};
    localparam int ETC_B [8] = '{8, 17, 29, 42, 60, 80, 106, 183};
    localparam int EAC [16][8] = '{
        '{-3, -6, -9, -15, 2, 5, 8, 14}, '{-3, -7, -10, -13, 2, 6, 9, 12},
        '{-2, -5, -8, -13, 1, 4, 7, 12}, '{-2, -4, -6, -13, 1, 3, 5, 12},
        '{-3, -6, -8, -12, 2, 5, 7, 11}, '{-3, -7, -9, -11, 2, 6, 8, 10},
        '{-4, -7, -8, -11, 3, 6, 7, 10}, '{-3, -5, -8, -11, 2, 4, 7, 10},
        '{-2, -6, -8, -10, 1, 5, 7, 9},  '{-2, -5, -8, -10, 1, 4, 7, 9},
        '{-2, -4, -8, -10, 1, 3, 7, 9},  '{-2, -5, -7, -10, 1, 4, 6, 9},
        '{-3, -4, -7, -10, 2, 3, 6, 9},  '{-1, -2, -3, -10, 0, 1, 2, 9},
        '{-4, -6, -8, -9, 3, 5, 7, 8},   '{-3, -5, -7, -9, 2, 4, 6, 8}
    };

    logic                 clk;
    logic                 rst_n;
    logic                 s_valid;
    logic                 s_ready;
    blk_t                 s_data;
    logic [TAG_W-1:0]     s_tag;
    logic                 m_valid;
    logic                 m_ready;
    logic [LANES*32-1:0]  m_rgba;
    logic [3:0]           m_beat;
    logic                 m_last;
    logic                 m_etc2;
    logic [TAG_W-1:0]     m_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    logic rdy_rand = 1'b0;

    exp_t exp_q[$];
    int   k          = 0;
    int   n_acc      = 0;
    int   n_blk_out  = 0;
    int   n_b2b      = 0;
    logic prev_stall = 1'b0;
    logic [LANES*32-1:0] sv_rgba;
    logic [3:0]          sv_beat;
    logic                sv_last;
    logic                sv_etc2;
    logic [TAG_W-1:0]    sv_tag;

    anf_fl_tex_etc_stream_decoder #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_tag   (s_tag),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_rgba  (m_rgba),
        .m_beat  (m_beat),
        .m_last  (m_last),
        .m_etc2  (m_etc2),
        .m_tag   (m_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp255(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic int sext3(input int d);
        return (d > 3) ? d - 8 : d;
    endfunction

    function automatic logic ref_esc(input blk_t b);
        int c1;
        int d;
        if (!b[33]) return 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            c1 = int'(b[63 - 8*ch -: 5]);
            d  = sext3(int'(b[58 - 8*ch -: 3]));
            if (c1 + d < 0 || c1 + d > 31) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Texel t = y*4+x of block b as {R,G,B,A}.
    function automatic logic [31:0] ref_texel(input blk_t b, input int t);
        int x;
        int y;
        int p;
        logic second;
        int cw;
        int mag;
        int mod;
        int c;
        int base;
        int hi;
        int a;
        int v[3];
        x = t % 4;
        y = t / 4;
        p = x * 4 + y;
        second = b[32] ? (y >= 2) : (x >= 2);
        cw  = second ? int'(b[36:34]) : int'(b[39:37]);
        mag = b[p] ? ETC_B[cw] : ETC_A[cw];
        mod = b[16 + p] ? -mag : mag;
        for (int ch = 0; ch < 3; ch++) begin
            hi = 63 - 8 * ch;
            if (!b[33]) begin
                base = 17 * (second ? int'(b[hi - 4 -: 4]) : int'(b[hi -: 4]));
            end else begin
                c = int'(b[hi -: 5]);
                if (second) c = (c + sext3(int'(b[hi - 5 -: 3]))) & 31;
                base = c * 8 + c / 4;
            end
            v[ch] = clamp255(base + mod);
        end
        if (ref_esc(b)) begin
            v[0] = 0;
            v[1] = 0;
            v[2] = 0;
        end
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
        a = clamp255(int'(b[127:120]) +
                     EAC[int'(b[115:112])][int'(b[111 - 3*p -: 3])] * int'(b[119:116]));
`else
        a = 255;
`endif
        return {8'(v[0]), 8'(v[1]), 8'(v[2]), 8'(a)};
    endfunction

    function automatic blk_t rand_block();
        blk_t b;
        for (int w = 0; w < int'(DW) / 32; w++) b[32*w +: 32] = $urandom;
        case ($urandom_range(0, 3))
            0: b[33] = 1'b0;
            1: b[33] = 1'b1;
            2: begin
                b[33] = 1'b1;
                b[63:59] = 5'd31;
                b[58:56] = 3'd3;
            end
            default: ;
        endcase
        return b;
    endfunction

    // Scoreboard: model every accepted block, check every output beat and stall stability.
    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        logic [511:0] er;
        if (!rst_n) begin
            exp_q.delete();
            k = 0;
            prev_stall = 1'b0;
            n_acc = n_blk_out;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 512'(m_valid), 512'(1));
                chk("stall_rgba", 512'(m_rgba), 512'(sv_rgba));
                chk("stall_beat", 512'(m_beat), 512'(sv_beat));
                chk("stall_last", 512'(m_last), 512'(sv_last));
                chk("stall_etc2", 512'(m_etc2), 512'(sv_etc2));
                chk("stall_tag", 512'(m_tag), 512'(sv_tag));
            end
            if (s_valid && s_ready) begin
                e.tx = '0;
                for (int t = 0; t < 16; t++) e.tx[32*t +: 32] = ref_texel(s_data, t);
                e.tag = s_tag;
                e.esc = ref_esc(s_data);
                exp_q.push_back(e);
                n_acc++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 512'(1), 512'(0));
                end else begin
                    e  = exp_q[0];
                    er = '0;
                    for (int l = 0; l < int'(LANES); l++)
                        er[32*l +: 32] = e.tx[32*(k*int'(LANES) + l) +: 32];
                    chk("rgba", 512'(m_rgba), er);
                    chk("beat", 512'(m_beat), 512'(k * int'(LANES)));
                    chk("last", 512'(m_last), 512'(k == int'(BEATS) - 1));
                    chk("etc2", 512'(m_etc2), 512'(e.esc));
                    chk("tag", 512'(m_tag), 512'(e.tag));
                    if (k == int'(BEATS) - 1) begin
                        k = 0;
                        void'(exp_q.pop_front());
                        n_blk_out++;
                        if (s_valid && s_ready) n_b2b++;
                    end else begin
                        k++;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            sv_rgba = m_rgba;
            sv_beat = m_beat;
            sv_last = m_last;
            sv_etc2 = m_etc2;
            sv_tag  = m_tag;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Present a block and hold it until accepted; returns just after the accepting edge.
    task automatic send_block(input blk_t b, input logic [TAG_W-1:0] tag);
        logic done;
        done = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        s_tag   = tag;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                acc_cyc = cyc;
                done = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk("accept_timeout", 512'(0), 512'(1));
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 512'(0), 512'(1));
    endtask

    initial begin
        int t0;
        logic found;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_tag   = '0;
        #12;
        chk("rst_m_valid", 512'(m_valid), 512'(0));
        chk("rst_m_last", 512'(m_last), 512'(0));
        chk("rst_m_etc2", 512'(m_etc2), 512'(0));
        chk("rst_m_rgba", 512'(m_rgba), 512'(0));
        chk("rst_m_beat", 512'(m_beat), 512'(0));
        chk("rst_m_tag", 512'(m_tag), 512'(0));
        chk("rst_s_ready", 512'(s_ready), 512'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_block(DW'(64'h8888_8800_0000_0000), 8'h01);
        s_valid = 1'b0;
        chk("lat_base", 512'(m_valid), 512'(0));
        @(posedge clk);
        #1;
        chk("lat_emit", 512'(m_valid), 512'(1));
`ifdef ANF_FL_TEX_EAC_ALPHA_EN
        chk("ind_rgba", 512'(m_rgba), 512'({4{32'h8A8A8A00}}));
`else
        chk("ind_rgba", 512'(m_rgba), 512'({4{32'h8A8A8AFF}}));
`endif
        wait_idle();

        send_block(DW'(64'hFFFF_FFFC_0000_FFFF), 8'h02);
        t0 = acc_cyc;
        send_block(DW'(64'h0000_00FC_FFFF_FFFF), 8'h03);
        chk("throughput1", 512'(acc_cyc - t0), 512'(BEATS + 1));
        t0 = acc_cyc;
        send_block(DW'(64'hF900_0002_0000_0000), 8'h04);
        chk("throughput2", 512'(acc_cyc - t0), 512'(BEATS + 1));
        send_block(DW'(64'h1200_0000_0000_0000), 8'h05);
        send_block(DW'(64'h1200_0001_0000_0000), 8'h06);
        s_valid = 1'b0;
        wait_idle();

        rdy_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_block(rand_block(), TAG_W'($urandom));
        end
        s_valid = 1'b0;
        wait_idle();
        rdy_rand = 1'b0;

        send_block(rand_block(), 8'hA5);
        s_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (m_valid && m_beat == 4'(LANES)) found = 1'b1;
        end
        chk("rst_beat1_seen", 512'(found), 512'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 512'(m_valid), 512'(0));
        chk("mid_rst_rgba", 512'(m_rgba), 512'(0));
        chk("mid_rst_last", 512'(m_last), 512'(0));
        chk("mid_rst_tag", 512'(m_tag), 512'(0));
        chk("mid_rst_s_ready", 512'(s_ready), 512'(1));
        #4;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", 512'(s_ready), 512'(1));
        send_block(DW'(64'h1200_0001_0000_0000), 8'h77);
        s_valid = 1'b0;
        wait_idle();

        chk("blocks_out", 512'(n_blk_out), 512'(n_acc));
        chk("b2b_seen", 512'(n_b2b != 0), 512'(1));
        chk("queue_empty", 512'(exp_q.size()), 512'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
